// File: rtl/adsr_envelope_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | adsr_pkg : state encoding shared by the ADSR envelope generator        |
// | Revision : 1.0                                                         |
// +-----------------------------------------------------------------------+
package adsr_pkg;

  localparam int ADSR_STATE_W = 3;

  typedef enum logic [ADSR_STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_e;

endpackage
`default_nettype wire

// File: rtl/adsr_envelope_sat_step.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | adsr_sat_step : saturating add (clamp at MAX) or subtract (clamp at    |
// |                 floor) with a flag for reaching the limit              |
// | Revision      : 1.0                                                    |
// +-----------------------------------------------------------------------+
module adsr_sat_step #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] floor_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] y_o,
  output logic             reached_o
);

  localparam logic [WIDTH-1:0] c_max = '1;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;

  assign w_sum  = {1'b0, a_i} + {1'b0, b_i};
  assign w_diff = (a_i > b_i) ? (a_i - b_i) : '0;

  // A zero step means "jump straight to the limit".
  always_comb begin
    y_o       = a_i;
    reached_o = 1'b0;
    if (sub_i) begin
      if ((b_i == '0) || (w_diff <= floor_i)) begin
        y_o       = floor_i;
        reached_o = 1'b1;
      end else begin
        y_o = w_diff;
      end
    end else begin
      if ((b_i == '0) || (w_sum >= {1'b0, c_max})) begin
        y_o       = c_max;
        reached_o = 1'b1;
      end else begin
        y_o = w_sum[WIDTH-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adsr_envelope.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | adsr_envelope : per-voice ADSR envelope and sample amplitude scaler    |
// | Option        : ADSR_EXP_RELEASE_EN selects an exponential release     |
// | Revision      : 1.0                                                    |
// +-----------------------------------------------------------------------+
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic                    inClk,
  input  logic                    inResetN,
  input  logic                    inSampleReady,
  input  logic [WIDTH-1:0]        inSample,
  input  logic                    inIsPlaying,
  input  logic [WIDTH-1:0]        inAttackRate,
  input  logic [WIDTH-1:0]        inDecayRate,
  input  logic [WIDTH-1:0]        inSustainLevel,
  input  logic [WIDTH-1:0]        inReleaseRate,
  output logic [WIDTH-1:0]        outSample,
  output logic                    outSampleReady,
  output logic [WIDTH-1:0]        outLevel,
  output logic [ADSR_STATE_W-1:0] outState,
  output logic                    outIsActive
);

  localparam logic [WIDTH-1:0] c_max = '1;
  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  adsr_state_e      state_q, state_d, w_phase;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic             ready_q, ready_d;

  logic [WIDTH-1:0] w_att_y, w_dec_y, w_rel_y, w_rel_dec;
  logic             w_att_hit, w_dec_hit, w_rel_hit;
  logic [WIDTH-1:0] w_scaled, w_unused_frac;

  assign {w_scaled, w_unused_frac} = {{WIDTH{1'b0}}, inSample} * {{WIDTH{1'b0}}, level_q};

`ifdef ADSR_EXP_RELEASE_EN
  logic [3:0]       w_rel_shift;
  logic [WIDTH-1:0] w_rel_shifted;
  logic             w_unused_rel;

  assign w_rel_shift   = inReleaseRate[3:0];
  assign w_rel_shifted = level_q >> w_rel_shift;
  assign w_rel_dec     = (w_rel_shift == 4'd0)    ? level_q :
                         (w_rel_shifted == '0)    ? c_one   : w_rel_shifted;
  assign w_unused_rel  = ^inReleaseRate[WIDTH-1:4];
`else
  assign w_rel_dec = inReleaseRate;
`endif

  adsr_sat_step #(.WIDTH(WIDTH)) u_attack (
    .a_i(level_q), .b_i(inAttackRate), .floor_i('0), .sub_i(1'b0),
    .y_o(w_att_y), .reached_o(w_att_hit)
  );

  adsr_sat_step #(.WIDTH(WIDTH)) u_decay (
    .a_i(level_q), .b_i(inDecayRate), .floor_i(inSustainLevel), .sub_i(1'b1),
    .y_o(w_dec_y), .reached_o(w_dec_hit)
  );

  adsr_sat_step #(.WIDTH(WIDTH)) u_release (
    .a_i(level_q), .b_i(w_rel_dec), .floor_i('0), .sub_i(1'b1),
    .y_o(w_rel_y), .reached_o(w_rel_hit)
  );

  // The gate picks which phase's step runs this strobe; a gate edge
  // therefore overrides the current state's own rate-driven exit.
  always_comb begin
    w_phase = state_q;
    unique case (state_q)
      ST_IDLE:    w_phase = inIsPlaying ? ST_ATTACK : ST_IDLE;
      ST_RELEASE: w_phase = inIsPlaying ? ST_ATTACK : ST_RELEASE;
      default:    w_phase = inIsPlaying ? state_q   : ST_RELEASE;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    sample_d = sample_q;
    ready_d  = 1'b0;
    if (inSampleReady) begin
      ready_d  = 1'b1;
      sample_d = (level_q == c_max) ? inSample : w_scaled;
      unique case (w_phase)
        ST_ATTACK: begin
          level_d = w_att_y;
          state_d = w_att_hit ? ST_DECAY : ST_ATTACK;
        end
        ST_DECAY: begin
          level_d = w_dec_y;
          state_d = w_dec_hit ? ST_SUSTAIN : ST_DECAY;
        end
        ST_SUSTAIN: begin
          level_d = inSustainLevel;
          state_d = ST_SUSTAIN;
        end
        ST_RELEASE: begin
          level_d = w_rel_y;
          state_d = w_rel_hit ? ST_IDLE : ST_RELEASE;
        end
        default: begin
          level_d = level_q;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge inClk) begin
    if (!inResetN) begin
      state_q  <= ST_IDLE;
      level_q  <= '0;
      sample_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      sample_q <= sample_d;
      ready_q  <= ready_d;
    end
  end

  assign outSample      = sample_q;
  assign outSampleReady = ready_q;
  assign outLevel       = level_q;
  assign outState       = state_q;
  assign outIsActive    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
- Parametrised ADSR envelope generator and amplitude scaler, next generation of the voice envelope follower.
- Per voice: gate (inIsPlaying) drives a five-state ADSR machine advancing once per sample strobe.
- Incoming unsigned sample multiplied by envelope level; result registered out with a valid pulse.
- Sits between oscillator sample stream and voice mixer; fully synchronous to one clock, no sample-strobe-as-clock.

Parameters:
- WIDTH, 12, bit width of samples, level, rates and sustain (unsigned).

Ports:
- inClk  in  1  system clock, all logic on rising edge.
- inResetN  in  1  reset, synchronous, active-low.
- inSampleReady  in  1  one-cycle strobe; new inSample valid, envelope advances.
- inSample  in  WIDTH  unsigned input sample.
- inIsPlaying  in  1  note gate; sampled only on strobe cycles.
- inAttackRate  in  WIDTH  level increment per strobe in ATTACK; 0 = instant.
- inDecayRate  in  WIDTH  level decrement per strobe in DECAY; 0 = instant.
- inSustainLevel  in  WIDTH  sustain target level.
- inReleaseRate  in  WIDTH  level decrement per strobe in RELEASE; 0 = instant.
- outSample  out  WIDTH  scaled sample.
- outSampleReady  out  1  one-cycle pulse, outSample updated.
- outLevel  out  WIDTH  current envelope level.
- outState  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- outIsActive  out  1  high when state != IDLE.

Behaviour:
- Reset (inResetN=0 at clock edge): state IDLE, level 0, outSample 0, outSampleReady 0; reset wins over simultaneous strobe; mid-note reset drops to IDLE immediately.
- Non-strobe cycles: state/level hold; outSampleReady 0.
- Strobe cycle k: outSample <= (inSample*level)>>WIDTH using pre-update level; if level == 2^WIDTH-1 then outSample <= inSample exactly. outSampleReady=1 at k+1. Level/state update at same edge.
- MAX = 2^WIDTH-1. All add/sub saturating (no wrap) at MAX and 0.
- IDLE: gate=1 -> ATTACK, this strobe already applies attack step.
- ATTACK: level <= sat(level+A); rate 0 or result >= MAX -> level MAX, state DECAY. Gate=0 -> RELEASE.
- DECAY: level <= max(level-D, S); rate 0 or reaching S -> SUSTAIN. S == MAX -> SUSTAIN directly. Gate=0 -> RELEASE.
- SUSTAIN: level <= inSustainLevel each strobe (tracks live changes). Gate=0 -> RELEASE.
- RELEASE: level <= sat(level-R); rate 0 or result 0 -> level 0, IDLE. Gate=1 -> ATTACK from current level (no restart from 0).
- Gate falling and level already 0 -> IDLE directly.
- Gate change takes priority over rate-driven transition on same strobe.
- Rate/sustain inputs may change any time; sampled on strobe only.

Optional Feature:
- Macro ADSR_EXP_RELEASE_EN.
- Defined: RELEASE decrement = max(level >> inReleaseRate[3:0], 1) (exponential tail); shift 0 gives instant 0.
- Undefined: linear release as above; inReleaseRate used whole.

Decomposition:
- Package adsr_pkg: state encoding constants (3-bit), ADSR_STATE_W.
- Sub-module adsr_sat_step: parametrised WIDTH saturating add/sub with floor operand and reached-limit flag; instantiated for attack, decay, release.

Test Plan (WIDTH=12):
- Reset held 3 cycles with strobes toggling -> outLevel 0, outState 0, outSample 0, outSampleReady never high.
- Gate=1, A=1024, strobes -> outLevel 1024, 2048, 3072, 4095; outState ATTACK until 4th strobe then DECAY.
- From 4095, D=500, S=3000 -> 3595, 3095, 3000; outState SUSTAIN; change S to 2500 -> next strobe 2500.
- Gate=0 at 3000, R=1000 -> 2000, 1000, 0; IDLE, outIsActive falls on last strobe edge; with macro, R=1 -> 1500, 750, 375.
- Release at 1000, gate=1, A=1024 -> 2024, ATTACK, no drop to 0; A=0 from IDLE -> 4095 in one strobe.
- Level 2048, inSample 4000 strobe -> outSample 2000 with outSampleReady one cycle later; level 4095, inSample 4000 -> 4000.
